// File: rtl/wb_pkg.sv
// Shared definitions for the data-cache write buffer.
//   DEPTH             : default number of buffered stores (power of 2, >= 2)
//   PTR_W             : head/tail pointer width
//   BLOCK_OFFSET_BITS : low address bits ignored when matching a refill block
//   wb_entry_t        : one buffered store {addr, data}
//   arb_t             : which client owns the memory port this cycle
package wb_pkg;

  localparam int DEPTH             = 4;
  localparam int PTR_W             = $clog2(DEPTH);
  localparam int BLOCK_OFFSET_BITS = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_t;

endpackage

// File: rtl/wb_fifo.sv
// Store FIFO for the write buffer: storage, pointers, occupancy count.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push         : write push_entry at tail (ignored while full)
//   push_entry   : store to enqueue
//   pop          : retire the head entry (ignored while empty)
//   head_entry   : oldest pending store
//   entry_valid  : per-slot valid bits, for the refill conflict compare
//   entry_addr   : per-slot store addresses, for the refill conflict compare
//   full, empty  : occupancy flags derived from the registered count
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = wb_pkg::DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head_entry,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [DEPTH-1:0][31:0] entry_addr,
  output logic                   full,
  output logic                   empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  wb_entry_t        store_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // head == tail with both active would need count 0 (no pop) or full
  // (no push), so the two valid-bit updates never hit the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (do_push) begin
        tail              <= tail + 1'b1;
        entry_valid[tail] <= 1'b1;
      end
      if (do_pop) begin
        head              <= head + 1'b1;
        entry_valid[head] <= 1'b0;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through valid slots.
  always_ff @(posedge clk) begin
    if (do_push) store_mem[tail] <= push_entry;
  end

  assign head_entry = store_mem[head];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = store_mem[i].addr;
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write buffer between the write-through data cache and single-ported memory.
// Queues every cache store, drains one word per cycle, and shares the memory
// port with cache refill reads. A refill is held off while any pending store
// targets the same cache block, so memory is always current when it is read.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data      : store request from the cache
//   wr_ready                   : buffer can take a store this cycle
//   rd_req/rd_addr             : refill read request
//   rd_grant/rd_data           : refill owns the port; rd_data is valid
//   mem_addr/mem_we/mem_wdata  : memory port, write sampled at posedge clk
//   mem_rdata                  : combinational memory read data
//   empty                      : no pending stores
// Handshake: a store transfers on a rising edge where wr_en and wr_ready are
// both high; while wr_ready is low the cache holds wr_en, wr_addr and wr_data
// stable. A refill word transfers in every cycle where rd_req and rd_grant
// are both high; rd_req with rd_grant low simply waits.
module dcache_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH             = wb_pkg::DEPTH,
  parameter int BLOCK_OFFSET_BITS = wb_pkg::BLOCK_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_grant,
  output logic [31:0] rd_data,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        empty
);

  wb_entry_t              head_entry;
  logic [DEPTH-1:0]       entry_valid;
  logic [DEPTH-1:0][31:0] entry_addr;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   conflict;
  arb_t                   arb_sel;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (wr_en),
    .push_entry ({wr_addr, wr_data}),
    .pop        (arb_sel == ARB_DRAIN),
    .head_entry (head_entry),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign wr_ready = !fifo_full;
  assign empty    = fifo_empty;
  assign rd_data  = mem_rdata;

  // Only stored entries are compared; a store arriving this cycle is not yet
  // in memory-order contention with the refill.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] &&
          entry_addr[i][31:BLOCK_OFFSET_BITS] == rd_addr[31:BLOCK_OFFSET_BITS])
        conflict = 1'b1;
    end
  end

  // A full buffer always drains so refills cannot starve stores forever.
  // Reset forces idle so an in-flight refill sees its grant drop at once.
  always_comb begin
    arb_sel = ARB_IDLE;
    if (!rst) begin
      if (fifo_full)                arb_sel = ARB_DRAIN;
      else if (rd_req && !conflict) arb_sel = ARB_READ;
      else if (!fifo_empty)         arb_sel = ARB_DRAIN;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    rd_grant  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (arb_sel)
      ARB_DRAIN: begin
        mem_we    = 1'b1;
        mem_addr  = head_entry.addr;
        mem_wdata = head_entry.data;
      end
      ARB_READ: begin
        rd_grant = 1'b1;
        mem_addr = rd_addr;
      end
      default: mem_addr = rst ? '0 : rd_addr;
    endcase
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;
  import wb_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_grant;
  logic [31:0] rd_data;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        empty;

  always #5 clk = ~clk;

  dcache_write_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_grant (rd_grant),
    .rd_data  (rd_data),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .empty    (empty)
  );

  // ---------------- memory model ----------------
  // Word i starts as {16'hC0DE, i}, so untouched words are recognisable.
  logic [31:0] mem [1024];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every memory write must be the next expected store, in order.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL drain_order actual=%h:%h required=%h:%h",
                   mem_addr, mem_wdata, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at #1 after a posedge; returns at #1 after the accepting posedge.
  task automatic push(input logic [31:0] a, input logic [31:0] d);
    bit done;
    done    = 1'b0;
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (wr_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    if (done) exp_q.push_back({a, d});
    else begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=stalled required=accepted addr=%h", a);
    end
  endtask

  task automatic wait_empty(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (empty) seen = 1'b1;
    end
    check(name, {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    #1;
    check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("reset_empty",    {31'd0, empty},    32'd1);
    check("reset_mem_we",   {31'd0, mem_we},   32'd1 - 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle();

    // Test 1: reset mid-operation; refill reads hold the stores back.
    rd_req = 1'b1; rd_addr = 32'h800;
    push(32'h900, 32'h0000_0091);
    push(32'h904, 32'h0000_0092);
    check("t1_pending_before_rst", {31'd0, empty}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_empty",    {31'd0, empty},    32'd1);
    check("t1_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("t1_rst_mem_we",   {31'd0, mem_we},   32'd0);
    check("t1_rst_rd_grant", {31'd0, rd_grant}, 32'd0);
    check("t1_rst_mem_addr", mem_addr,          32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0; rd_req = 1'b0;
    repeat (5) cycle();
    check("t1_mem_900_untouched", mem[32'h900 >> 2], 32'hC0DE_0240);
    check("t1_mem_904_untouched", mem[32'h904 >> 2], 32'hC0DE_0241);

    // Test 2: basic drain.
    push(32'h100, 32'hAAAA_0001);
    push(32'h104, 32'hAAAA_0002);
    wait_empty("t2_empty_after");
    check("t2_mem_100", mem[32'h100 >> 2], 32'hAAAA_0001);
    check("t2_mem_104", mem[32'h104 >> 2], 32'hAAAA_0002);

    // Test 3: fill under a non-conflicting refill, then backpressure.
    rd_req = 1'b1; rd_addr = 32'h800;
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(4 * i), 32'h3333_0001 + 32'(i));
    @(negedge clk);
    check("t3_full_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("t3_full_mem_we",   {31'd0, mem_we},   32'd1);
    check("t3_full_rd_grant", {31'd0, rd_grant}, 32'd0);
    check("t3_full_mem_addr", mem_addr,          32'h600);
    cycle();
    push(32'h610, 32'h3333_0005);
    rd_req = 1'b0;
    wait_empty("t3_empty_after");
    check("t3_mem_600", mem[32'h600 >> 2], 32'h3333_0001);
    check("t3_mem_610", mem[32'h610 >> 2], 32'h3333_0005);

    // Test 4: refill has priority over a non-full buffer.
    rd_req = 1'b1; rd_addr = 32'h300;
    push(32'h200, 32'h0000_2222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_rd_grant", {31'd0, rd_grant}, 32'd1);
      check("t4_mem_addr", mem_addr,          32'h300);
      check("t4_rd_data",  rd_data,           32'hC0DE_00C0);
      check("t4_mem_we",   {31'd0, mem_we},   32'd0);
      cycle();
    end
    rd_req = 1'b0;
    @(negedge clk);
    check("t4_drain_after_req", mem_addr, 32'h200);
    cycle();
    wait_empty("t4_empty_after");

    // Test 5: block conflict holds the refill until the matching store lands.
    rd_req = 1'b1; rd_addr = 32'h800;
    push(32'h20C, 32'h0000_5555);
    push(32'h400, 32'h0000_0001);
    rd_addr = 32'h20C;
    @(negedge clk);
    check("t5_conflict_grant", {31'd0, rd_grant}, 32'd0);
    check("t5_conflict_we",    {31'd0, mem_we},   32'd1);
    check("t5_conflict_addr",  mem_addr,          32'h20C);
    cycle();
    @(negedge clk);
    check("t5_grant",       {31'd0, rd_grant}, 32'd1);
    check("t5_grant_addr",  mem_addr,          32'h20C);
    check("t5_grant_data",  rd_data,           32'h0000_5555);
    check("t5_400_pending", {31'd0, empty},    32'd0);
    cycle();
    rd_req = 1'b0;
    wait_empty("t5_empty_after");
    check("t5_mem_400", mem[32'h400 >> 2], 32'h0000_0001);

    // Test 6: same-address stores, last write wins.
    push(32'h10, 32'd1);
    push(32'h10, 32'd2);
    push(32'h10, 32'd3);
    wait_empty("t6_empty_after");
    check("t6_mem_10", mem[32'h10 >> 2], 32'd3);

    repeat (3) cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
